// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style control unit: a Moore/Mealy FSM that sequences fetch,
// decode, execute, memory and writeback, driving the datapath mux and write-enable controls.
module multi_cycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'd0,
    parameter logic [5:0] OP_LW    = 6'd35,
    parameter logic [5:0] OP_SW    = 6'd43,
    parameter logic [5:0] OP_BEQ   = 6'd4,
    parameter logic [5:0] OP_BNE   = 6'd5,
    parameter logic [5:0] OP_J     = 6'd2,
    parameter logic [5:0] OP_ADDI  = 6'd8,
    parameter logic [5:0] OP_LUI   = 6'd15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic       illegal_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EXEC = 4'd10,
        S_IMM_WB   = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   imm_alu_lui;

    assign state       = state_q;
    assign imm_alu_lui = (opcode == OP_LUI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        illegal_op    = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEM_ADDR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (opcode == OP_ADDI || opcode == OP_LUI) begin
                    state_d = S_IMM_EXEC;
                end else begin
                    illegal_op = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                state_d   = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = (opcode == OP_BNE);
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = imm_alu_lui ? 2'b11 : 2'b00;
                state_d   = S_IMM_WB;
            end
            S_IMM_WB: begin
                reg_write = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = imm_alu_lui ? 2'b11 : 2'b00;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset holds the state in FETCH, whose fetch strobes must not leak out.
        if (!rst_n) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_write     = 1'b0;
            pc_write_cond = 1'b0;
            illegal_op    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized bench for multi_cycle_ctrl: an instruction-path model predicts
// the state walk, control word and latency of each instruction.
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    multi_cycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .illegal_op(illegal_op),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
        logic ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
        logic [1:0] alu_src_b, alu_op, pc_source;
    } ctl_t;

    ctl_t got;
    assign got = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
                  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op,
                  alu_src_b, alu_op, pc_source};

    int n_cmp = 0;
    int n_bad = 0;
    int path[$];
    int pidx = 0;
    int exp_st = 0;
    int cnt_mw, cnt_rw, cnt_ill, cnt_pw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_legal(input int op);
        return op inside {0, 35, 43, 4, 5, 2, 8, 15};
    endfunction

    // Path of states an instruction visits, from its opcode class.
    function automatic void build_path(input int op);
        case (op)
            35:      path = '{0, 1, 2, 3, 4};
            43:      path = '{0, 1, 2, 5};
            0:       path = '{0, 1, 6, 7};
            4, 5:    path = '{0, 1, 8};
            2:       path = '{0, 1, 9};
            8, 15:   path = '{0, 1, 10, 11};
            default: path = '{0, 1};
        endcase
    endfunction

    function automatic int base_latency(input int op);
        case (op)
            35:              return 5;
            43, 0, 8, 15:    return 4;
            4, 5, 2:         return 3;
            default:         return 2;
        endcase
    endfunction

    function automatic ctl_t exp_ctl(input int st, input int op, input logic mr, input logic rn);
        ctl_t c;
        c = '0;
        case (st)
            0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
            1:  begin c.alu_src_b = 2'b11; c.illegal_op = !is_legal(op); end
            2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            3:  begin c.mem_read = 1; c.i_or_d = 1; end
            4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            5:  begin c.mem_write = 1; c.i_or_d = 1; end
            6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            7:  begin c.reg_write = 1; c.reg_dst = 1; end
            8:  begin
                    c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                    c.pc_source = 2'b01; c.branch_ne = (op == 5);
                end
            9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
            10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = (op == 15) ? 2'b11 : 2'b00; end
            11: begin c.reg_write = 1; c.alu_src_b = 2'b10; c.alu_op = (op == 15) ? 2'b11 : 2'b00; end
            default: c = '0;
        endcase
        if (!rn) begin
            c.pc_write = 0; c.ir_write = 0; c.reg_write = 0;
            c.mem_write = 0; c.pc_write_cond = 0; c.illegal_op = 0;
        end
        return c;
    endfunction

    // One clock: drive mem_ready, check at the falling edge, advance the model.
    task automatic cycle(input logic mr);
        int nw;
        bit ok;
        mem_ready = mr;
        @(negedge clk);
        chk("state", 32'(state), 32'(exp_st));
        chk("ctl", 32'(got), 32'(exp_ctl(exp_st, int'(opcode), mr, rst_n)));
        nw = int'(pc_write) + int'(ir_write) + int'(reg_write) + int'(mem_write);
        ok = (nw <= 1) || (nw == 2 && pc_write && ir_write && state == 4'd0);
        chk("wr_excl", 32'(ok), 32'd1);
        cnt_mw  += int'(mem_write);
        cnt_rw  += int'(reg_write);
        cnt_ill += int'(illegal_op);
        cnt_pw  += int'(pc_write);
        @(posedge clk);
        #1;
        if (rst_n && !((exp_st == 0 || exp_st == 3 || exp_st == 5) && !mr)) begin
            pidx++;
            if (pidx >= path.size()) begin
                pidx = 0;
                exp_st = 0;
            end else begin
                exp_st = path[pidx];
            end
        end
    endtask

    task automatic run_instr(input int op, input int wf, input int wm);
        int f, m, lat;
        bit left;
        logic mr;
        f = wf; m = wm; lat = 0; left = 0;
        cnt_mw = 0; cnt_rw = 0; cnt_ill = 0; cnt_pw = 0;
        opcode = 6'(op);
        build_path(op);
        pidx = 0;
        while (lat < 100) begin
            if (exp_st == 0 && f > 0) begin mr = 0; f--; end
            else if ((exp_st == 3 || exp_st == 5) && m > 0) begin mr = 0; m--; end
            else mr = 1;
            cycle(mr);
            lat++;
            if (exp_st != 0) left = 1;
            else if (left) break;
        end
        chk("latency", 32'(lat), 32'(base_latency(op) + wf + ((op == 35 || op == 43) ? wm : 0)));
    endtask

    initial begin
        int op;
        cnt_mw = 0; cnt_rw = 0; cnt_ill = 0; cnt_pw = 0;
        path = '{0};
        @(posedge clk);
        #1;
        cycle(1'b1);
        cycle(1'b1);
        rst_n = 1'b1;

        run_instr(35, 0, 0);
        chk("lw_rw_cnt", 32'(cnt_rw), 32'd1);
        run_instr(43, 0, 3);
        chk("sw_mw_cnt", 32'(cnt_mw), 32'd4);
        chk("sw_rw_cnt", 32'(cnt_rw), 32'd0);
        run_instr(5, 0, 0);
        run_instr(4, 1, 0);
        run_instr(15, 0, 0);
        run_instr(8, 0, 0);
        run_instr(0, 0, 0);
        run_instr(2, 2, 0);
        run_instr(63, 0, 0);
        chk("ill_cnt", 32'(cnt_ill), 32'd1);
        chk("ill_pw_cnt", 32'(cnt_pw), 32'd1);
        run_instr(35, 2, 2);

        // Asynchronous reset mid-store, while waiting in MEM_WR.
        opcode = 6'd43;
        build_path(43);
        pidx = 0;
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b1);
        mem_ready = 1'b0;
        #1;
        chk("pre_rst_mw", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mw", 32'(mem_write), 32'd0);
        exp_st = 0;
        pidx = 0;
        @(posedge clk);
        #1;
        cycle(1'b1);
        rst_n = 1'b1;
        run_instr(2, 0, 0);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) op = int'($urandom_range(0, 63));
            else begin
                case ($urandom_range(0, 7))
                    0: op = 35; 1: op = 43; 2: op = 0; 3: op = 4;
                    4: op = 5;  5: op = 2;  6: op = 8; default: op = 15;
                endcase
            end
            run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
